fifo_stream_reader: RTL and testbench



---
 rtl/nautilus_fifo_pkg.sv | 14 +
 rtl/fifo_rd_skid.sv | 55 +++++
 rtl/fifo_stream_reader.sv | 105 ++++++++++
 tb/tb_fifo_stream_reader.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nautilus_fifo_pkg.sv
// rtl/nautilus_fifo_pkg.sv - shared defaults and FSM state type for the FIFO stream reader
// Contents: DATA_W_DEF, BURST_LEN_DEF, rd_state_e {IDLE, RUN, FLUSH}.
package nautilus_fifo_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int BURST_LEN_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - 2-entry output buffer between FIFO read data and the stream
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   push        write push_data into the tail entry
//   push_data   data captured on push
//   pop         retire the head entry
//   occ         number of valid entries (0..2)
//   head_data   oldest entry (0 after reset)
module fifo_rd_skid #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [1:0]        occ,
  output logic [DATA_W-1:0] head_data
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Push and pop together leave occupancy unchanged; the pointers keep order.
      case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  assign head_data = mem[rd_ptr];

  // The read-issue rule upstream must never let a capture land in a full buffer.
  assert property (@(posedge clk) disable iff (rst) !(push && occ == 2'd2));
  assert property (@(posedge clk) disable iff (rst) !(pop && occ == 2'd0));

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains a FIFO into a valid/ready stream with burst framing
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   enable             1 = drain FIFO, 0 = stop reads and flush buffered data
//   fifo_empty         FIFO empty flag (combinational from FIFO)
//   fifo_rd_en         FIFO read request, never raised while fifo_empty=1
//   fifo_rd_data       FIFO data, valid one cycle after an accepted read
//   m_valid/m_ready    stream handshake
//   m_data, m_last     stream beat and end-of-burst marker
//   busy               FSM not in IDLE
//   word_cnt           beats transferred since reset, wraps at 16 bits
module fifo_stream_reader
  import nautilus_fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_rd_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              busy,
  output logic [15:0]       word_cnt
);

  localparam int                IDX_W    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(BURST_LEN - 1);

  rd_state_e        state;
  rd_state_e        state_nxt;
  logic             inflight;
  logic [1:0]       occ;
  logic             pop;
  logic [IDX_W-1:0] burst_idx;

  fifo_rd_skid #(.DATA_W(DATA_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .occ       (occ),
    .head_data (m_data)
  );

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid & m_ready;
  assign m_last  = m_valid & (burst_idx == LAST_IDX);
  assign busy    = (state != IDLE);

  always_comb begin
    state_nxt  = state;
    fifo_rd_en = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) state_nxt = FLUSH;
        // Reads stop in the very cycle enable drops so a flush drains at most
        // the buffered beat plus the one already in flight.
        // occ + inflight - pop < 2, rearranged to stay unsigned.
        if (enable && !fifo_empty) begin
          fifo_rd_en = ({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
        end
      end
      FLUSH: begin
        if (enable) begin
          state_nxt = RUN;
        end else if (occ == 2'd0 && !inflight) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      inflight  <= 1'b0;
      burst_idx <= '0;
      word_cnt  <= 16'd0;
    end else begin
      state    <= state_nxt;
      // fifo_rd_en is only raised while fifo_empty=0, so every request is accepted.
      inflight <= fifo_rd_en;
      if (pop) word_cnt <= word_cnt + 16'd1;
      // A partial burst is abandoned on the way to IDLE; no pop can coincide
      // because IDLE is only entered with an empty buffer.
      if (state_nxt == IDLE) begin
        burst_idx <= '0;
      end else if (pop) begin
        burst_idx <= (burst_idx == LAST_IDX) ? '0 : burst_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - self-checking bench for fifo_stream_reader
module tb_fifo_stream_reader;

  localparam int DW = 32;
  localparam int BL = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          fifo_empty = 1'b1;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          busy;
  logic [15:0]   word_cnt;

  logic          enable1 = 1'b0;
  logic          empty1 = 1'b1;
  logic          rd_en1;
  logic [DW-1:0] rd_data1 = '0;
  logic          m_valid1;
  logic          ready1 = 1'b1;
  logic [DW-1:0] m_data1;
  logic          m_last1;
  logic          busy1;
  logic [15:0]   wcnt1;

  always #5 clk = ~clk;

  fifo_stream_reader #(.DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .word_cnt(word_cnt)
  );

  fifo_stream_reader #(.DATA_W(DW), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst), .enable(enable1), .fifo_empty(empty1),
    .fifo_rd_en(rd_en1), .fifo_rd_data(rd_data1),
    .m_valid(m_valid1), .m_ready(ready1), .m_data(m_data1), .m_last(m_last1),
    .busy(busy1), .word_cnt(wcnt1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference FIFO and expected stream order.
  logic [DW-1:0] fq[$];
  logic [DW-1:0] eq[$];
  int            rd_empty_viol = 0;

  always @(posedge clk) begin
    if (!rst && fifo_rd_en) begin
      if (fifo_empty) rd_empty_viol++;
      else if (fq.size() > 0) fifo_rd_data <= fq.pop_front();
    end
    fifo_empty <= (fq.size() == 0);
  end

  // m_ready pattern: 0 = always, 1 = toggle, 2 = random, 3 = held low
  int rmode = 0;
  always @(posedge clk) begin
    #2;
    case (rmode)
      0:       m_ready = 1'b1;
      1:       m_ready = !m_ready;
      2:       m_ready = 1'($urandom_range(0, 1));
      default: m_ready = 1'b0;
    endcase
  end

  // Stream monitor: order, burst framing (beat k of a burst is last when k = BL-1), stall stability.
  int            beats = 0;
  int            lasts = 0;
  int            model_idx = 0;
  logic          stalled = 1'b0;
  logic [DW-1:0] stall_data = '0;
  logic [DW-1:0] exp_d;

  always @(negedge clk) begin
    if (rst) begin
      beats = 0; lasts = 0; model_idx = 0; stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("stall_valid_held", m_valid, 1);
        check("stall_data_held", m_data, stall_data);
      end
      stalled    = m_valid && !m_ready;
      stall_data = m_data;
      if (m_valid && m_ready) begin
        if (eq.size() == 0) begin
          check("beat_unexpected", m_valid, 0);
        end else begin
          exp_d = eq.pop_front();
          check("beat_data", m_data, exp_d);
        end
        check("beat_last", m_last, (model_idx == BL - 1));
        model_idx = (model_idx + 1) % BL;
        beats++;
        if (m_last) lasts++;
      end
    end
  end

  // BURST_LEN=1 instance: FIFO supplies 0x700, 0x701, ... up to f1_total words.
  int f1_total = 0;
  int f1_reads = 0;
  int beats1 = 0;

  always @(posedge clk) begin
    if (rst) begin
      f1_reads = 0;
      empty1 <= 1'b1;
    end else begin
      if (rd_en1 && !empty1) begin
        rd_data1 <= 32'h700 + f1_reads;
        f1_reads++;
      end
      empty1 <= (f1_reads >= f1_total);
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      beats1 = 0;
    end else if (m_valid1 && ready1) begin
      check("bl1_data", m_data1, 32'h700 + beats1);
      check("bl1_last", m_last1, 1);
      beats1++;
    end
  end

  task automatic push_word(input logic [DW-1:0] d);
    fq.push_back(d);
    eq.push_back(d);
  endtask

  task automatic preload(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) push_word(base + DW'(i));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    enable = 1'b0;
    fq.delete();
    eq.delete();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic wait_beats(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (beats < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    if (beats < n) check({name, "_timeout"}, beats, n);
  endtask

  typedef struct {
    int n_words;
    int rmode;
    int exp_beats;
    int exp_lasts;
  } vec_t;

  vec_t vecs[5];
  int   lat;
  int   pre;
  int   c;
  int   pushed;
  int   k;

  initial begin
    vecs[0] = '{20, 0, 20, 1};
    vecs[1] = '{8,  1, 8,  0};
    vecs[2] = '{16, 2, 16, 1};
    vecs[3] = '{3,  0, 3,  0};
    vecs[4] = '{33, 2, 33, 2};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_rd_en", fifo_rd_en, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_m_data", m_data, 0);
    check("rst_word_cnt", word_cnt, 0);

    // Table-driven bursts: preload from 0x100, enable, drain fully.
    for (int v = 0; v < 5; v++) begin
      do_reset();
      rmode = vecs[v].rmode;
      preload(vecs[v].n_words, 32'h100);
      enable = 1'b1;
      lat = 0;
      while (!m_valid && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      check("first_valid_latency_ok", (lat <= 3), 1);
      wait_beats(vecs[v].exp_beats, 300, "vec");
      repeat (8) @(posedge clk);
      #1;
      check("vec_beats", beats, vecs[v].exp_beats);
      check("vec_lasts", lasts, vecs[v].exp_lasts);
      check("vec_word_cnt", word_cnt, vecs[v].exp_beats);
      check("vec_fifo_drained", fq.size(), 0);
      check("vec_valid_idle", m_valid, 0);
      check("vec_busy_run", busy, 1);
    end

    // Enable dropped after 4 pops: at most 2 more beats, then IDLE.
    do_reset();
    rmode = 0;
    preload(10, 32'h300);
    enable = 1'b1;
    wait_beats(4, 100, "flush_pre");
    enable = 1'b0;
    pre = beats;
    c = 0;
    while (busy && c < 50) begin
      @(posedge clk); #1;
      c++;
    end
    check("flush_busy_falls", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    check("flush_extra_le2", ((beats - pre) <= 2), 1);
    check("flush_fifo_retains", fq.size(), 10 - beats);
    check("flush_no_last", lasts, 0);
    check("flush_word_cnt", word_cnt, beats);
    check("flush_valid_low", m_valid, 0);

    // FIFO runs dry after 5 words; burst index must survive the gap.
    do_reset();
    rmode = 0;
    preload(5, 32'h400);
    enable = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("gap_beats", beats, 5);
    check("gap_valid_low", m_valid, 0);
    check("gap_busy", busy, 1);
    preload(11, 32'h405);
    wait_beats(16, 100, "gap");
    repeat (4) @(posedge clk);
    #1;
    check("gap_total", beats, 16);
    check("gap_lasts", lasts, 1);

    // Reset with 2 buffered beats, then a single-word preload.
    do_reset();
    rmode = 0;
    preload(6, 32'h500);
    enable = 1'b1;
    wait_beats(2, 50, "rst_pre");
    rmode = 3;
    repeat (10) @(posedge clk);
    #1;
    check("pre_rst_valid", m_valid, 1);
    check("pre_rst_word_cnt", word_cnt, 2);
    rst = 1'b1;
    #1;
    check("async_rst_valid", m_valid, 0);
    check("async_rst_word_cnt", word_cnt, 0);
    check("async_rst_busy", busy, 0);
    fq.delete();
    eq.delete();
    repeat (2) @(posedge clk);
    #1;
    preload(1, 32'h600);
    rmode = 0;
    rst = 1'b0;
    #1;
    check("no_read_before_edge1", fifo_rd_en, 0);
    wait_beats(1, 50, "post_rst");
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_beats", beats, 1);
    check("post_rst_word_cnt", word_cnt, 1);

    // Random refills and random back-pressure against the queue model.
    do_reset();
    rmode = 2;
    enable = 1'b1;
    pushed = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(1, 3);
        for (int j = 0; j < k; j++) push_word($urandom);
        pushed += k;
      end
    end
    wait_beats(pushed, 1500, "rand");
    repeat (6) @(posedge clk);
    #1;
    check("rand_beats", beats, pushed);
    check("rand_word_cnt", word_cnt, pushed);
    check("rand_lasts", lasts, pushed / BL);
    check("rand_fifo_drained", fq.size(), 0);

    // BURST_LEN=1: every beat is last.
    f1_total = 3;
    enable1 = 1'b1;
    c = 0;
    while (beats1 < 3 && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    repeat (6) @(posedge clk);
    #1;
    check("bl1_beats", beats1, 3);
    check("bl1_word_cnt", wcnt1, 3);

    check("rd_while_empty", rd_empty_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
